// File: rtl/a51_byte_encryptor.sv
// Packs the A5/1 keystream into bytes, buffers them in a small FIFO and XORs
// them with handshaked plaintext to produce one frame of ciphertext.
module a51_byte_encryptor #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned FRAME_BYTES = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_ok,
  input  logic       keystream,
  input  logic [7:0] pt_data,
  input  logic       pt_valid,
  output logic       pt_ready,
  output logic [7:0] ct_data,
  output logic       ct_valid,
  input  logic       ct_ready,
  output logic       frame_done,
  output logic       overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    sr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    push_cnt;
  logic [7:0]    acc_cnt;
  logic          pack_en, byte_rdy, fifo_full, push, pop, xfer;

  // Handshake and FIFO control; the generator cannot stall, so a full FIFO drops.
  always_comb begin
    pack_en   = (state != DONE) && init_ok && (push_cnt < 8'(FRAME_BYTES));
    byte_rdy  = pack_en && (bit_cnt == 3'd7);
    fifo_full = (count == CW'(FIFO_DEPTH));
    pt_ready  = (state == RUN) && (count != '0) && (!ct_valid || ct_ready);
    xfer      = pt_valid && pt_ready;
    pop       = xfer;
    push      = byte_rdy && (!fifo_full || pop);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (init_ok) state_nxt = RUN;
      RUN:     if (xfer && (acc_cnt == 8'(FRAME_BYTES - 1))) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // MSB-first packer; losing init_ok throws away any partial byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (pack_en) begin
      sr      <= {sr[6:0], keystream};
      bit_cnt <= bit_cnt + 3'd1;
    end else if (!init_ok) begin
      sr      <= '0;
      bit_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sr[6:0], keystream};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      push_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        push_cnt <= push_cnt + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (byte_rdy && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // Output register holds its byte until the sink takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ct_data    <= '0;
      ct_valid   <= 1'b0;
      acc_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (xfer) begin
      ct_data  <= pt_data ^ mem[rd_ptr];
      ct_valid <= 1'b1;
      acc_cnt  <= acc_cnt + 8'd1;
      if (acc_cnt == 8'(FRAME_BYTES - 1)) frame_done <= 1'b1;
    end else if (ct_ready) begin
      ct_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_a51_byte_encryptor.sv
// Bench for a51_byte_encryptor: fixed vectors, corner-case sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_a51_byte_encryptor;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_ok = 1'b0;
  logic       keystream = 1'b0;
  logic [7:0] pt_data = 8'h00;
  logic       pt_valid = 1'b0;
  logic       pt_ready;
  logic [7:0] ct_data;
  logic       ct_valid;
  logic       ct_ready = 1'b1;
  logic       frame_done;
  logic       overflow;

  a51_byte_encryptor #(.FIFO_DEPTH(DEPTH), .FRAME_BYTES(FRAME)) dut (
    .clk(clk), .rst(rst), .init_ok(init_ok), .keystream(keystream),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: keystream bytes as a queue, frame progress as counters.
  logic [7:0] mq[$];
  int         m_nbits, m_pushed, m_acc;
  logic [7:0] m_cur, m_ctd;
  bit         m_started, m_done, m_ovf, m_ctv;
  bit         last_acc;
  int         n_hs;

  typedef struct {
    logic [7:0] ks;
    logic [7:0] pt;
    logic [7:0] ct;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_nbits = 0; m_pushed = 0; m_acc = 0; m_cur = 8'h00; m_ctd = 8'h00;
    m_started = 0; m_done = 0; m_ovf = 0; m_ctv = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, return 1 ns after the rising edge.
  task automatic step();
    bit exp_ready, acc;
    logic [7:0] head;
    @(negedge clk);
    exp_ready = m_started && !m_done && (mq.size() != 0) && (!m_ctv || ct_ready);
    chk("pt_ready", {31'd0, pt_ready}, {31'd0, exp_ready});
    chk("ct_valid", {31'd0, ct_valid}, {31'd0, m_ctv});
    chk("ct_data", {24'd0, ct_data}, {24'd0, m_ctd});
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_done});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    acc = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (ct_valid && ct_ready) n_hs++;
      acc = pt_valid && exp_ready;
      if (acc) begin
        head  = mq.pop_front();
        m_ctd = pt_data ^ head;
        m_ctv = 1;
        m_acc++;
      end else if (ct_ready) begin
        m_ctv = 0;
      end
      if (!m_done && init_ok && m_pushed < int'(FRAME)) begin
        m_cur = {m_cur[6:0], keystream};
        m_nbits++;
        if (m_nbits == 8) begin
          m_nbits = 0;
          if (mq.size() < int'(DEPTH)) begin
            mq.push_back(m_cur);
            m_pushed++;
          end else begin
            m_ovf = 1;
          end
        end
      end else if (!init_ok) begin
        m_nbits = 0;
        m_cur   = 8'h00;
      end
      if (acc && m_acc == int'(FRAME)) m_done = 1;
      if (!m_started && init_ok) m_started = 1;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; init_ok = 1'b0; pt_valid = 1'b0; ct_ready = 1'b1; keystream = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      keystream = b[i];
      step();
    end
    keystream = 1'b0;
  endtask

  initial begin
    logic [7:0] ksb[DEPTH+1];
    logic [7:0] held;
    int cyc, n;

    vecs[0] = '{ks: 8'hFF, pt: 8'hA5, ct: 8'h5A};
    vecs[1] = '{ks: 8'hB2, pt: 8'hFF, ct: 8'h4D};
    vecs[2] = '{ks: 8'h00, pt: 8'h3C, ct: 8'h3C};
    vecs[3] = '{ks: 8'h5A, pt: 8'h5A, ct: 8'h00};
    vecs[4] = '{ks: 8'hC3, pt: 8'h96, ct: 8'h55};

    model_reset();
    do_reset();
    chk("reset_ct_valid", {31'd0, ct_valid}, 32'd0);
    chk("reset_pt_ready", {31'd0, pt_ready}, 32'd0);

    // Fixed vectors: one packed keystream byte against one plaintext byte.
    foreach (vecs[v]) begin
      do_reset();
      init_ok = 1'b1;
      feed_byte(vecs[v].ks);
      pt_data = vecs[v].pt; pt_valid = 1'b1;
      step();
      pt_valid = 1'b0;
      chk("vec_ct_valid", {31'd0, ct_valid}, 32'd1);
      chk("vec_ct_data", {24'd0, ct_data}, {24'd0, vecs[v].ct});
    end

    // First-accept latency with an all-ones keystream.
    do_reset();
    init_ok = 1'b1; keystream = 1'b1; pt_data = 8'hA5; pt_valid = 1'b1;
    cyc = 0;
    while (!pt_ready && cyc < 40) begin
      step();
      cyc++;
    end
    chk("t1_first_ready_cycle", 32'(cyc), 32'd8);
    step();
    chk("t1_ct_valid", {31'd0, ct_valid}, 32'd1);
    chk("t1_ct_data", {24'd0, ct_data}, 32'h5A);
    pt_valid = 1'b0;

    // Overflow with the sink idle, then in-order drain of the retained bytes.
    do_reset();
    init_ok = 1'b1;
    for (int b = 0; b < int'(DEPTH) + 1; b++) begin
      for (int i = 7; i >= 0; i--) begin
        keystream = 1'($urandom);
        ksb[b][i] = keystream;
        step();
      end
    end
    keystream = 1'b0;
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    pt_data = 8'h00; pt_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && n < int'(DEPTH); k++) begin
      step();
      if (last_acc) begin
        chk("t3_order", {24'd0, ct_data}, {24'd0, ksb[n]});
        n++;
      end
    end
    chk("t3_drain_count", 32'(n), 32'(DEPTH));
    chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);
    pt_valid = 1'b0;

    // Sink stall while a ciphertext byte is pending.
    do_reset();
    init_ok = 1'b1; pt_data = 8'h3E; pt_valid = 1'b1;
    cyc = 0;
    while (!ct_valid && cyc < 40) begin
      keystream = 1'($urandom);
      step();
      cyc++;
    end
    chk("t4_got_ct", {31'd0, ct_valid}, 32'd1);
    held = ct_data;
    ct_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      keystream = 1'($urandom);
      step();
      chk("t4_ct_stable", {24'd0, ct_data}, {24'd0, held});
      chk("t4_pt_ready_low", {31'd0, pt_ready}, 32'd0);
    end
    ct_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      keystream = 1'($urandom);
      step();
    end
    pt_valid = 1'b0;

    // Full frame: exactly FRAME bytes then the block stops.
    do_reset();
    init_ok = 1'b1; pt_valid = 1'b1;
    n = 0; n_hs = 0;
    for (int k = 0; k < int'(FRAME) * 8 + 40; k++) begin
      keystream = 1'($urandom);
      pt_data = 8'($urandom);
      step();
      if (last_acc) n++;
    end
    chk("t5_accepts", 32'(n), 32'(FRAME));
    chk("t5_ct_handshakes", 32'(n_hs), 32'(FRAME));
    chk("t5_frame_done", {31'd0, frame_done}, 32'd1);
    chk("t5_pt_ready_low", {31'd0, pt_ready}, 32'd0);
    pt_valid = 1'b0;

    // init_ok glitch discards a partial byte.
    do_reset();
    init_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      keystream = 1'($urandom);
      step();
    end
    init_ok = 1'b0;
    for (int k = 0; k < 3; k++) step();
    init_ok = 1'b1;
    feed_byte(8'h6E);
    pt_data = 8'h11; pt_valid = 1'b1;
    step();
    chk("t6_resumed_byte", {24'd0, ct_data}, 32'h7F);
    for (int k = 0; k < 20; k++) begin
      keystream = 1'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_ct_data", {24'd0, ct_data}, 32'd0);
    chk("t6_rst_ct_valid", {31'd0, ct_valid}, 32'd0);
    chk("t6_rst_pt_ready", {31'd0, pt_ready}, 32'd0);
    chk("t6_rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("t6_rst_overflow", {31'd0, overflow}, 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      rst       = ($urandom_range(0, 299) == 0);
      init_ok   = ($urandom_range(0, 19) != 0);
      keystream = 1'($urandom);
      pt_valid  = 1'($urandom);
      pt_data   = 8'($urandom);
      ct_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
